// File: rtl/skid_pipeline.sv
// ---------------------------------------------------------------------------
// skid_pipeline
//   Multi-stage valid/ready retiming pipeline. Each stage is either a
//   two-entry skid buffer (REG_READY=1), whose upstream ready is a register
//   and so cuts the combinational ready path, or a single-entry register
//   (REG_READY=0), whose ready is ~valid | downstream ready. Both modes sustain
//   one beat per cycle. Includes a synchronous flush and a registered count of
//   held entries.
//
// Parameters
//   DATA_W    payload width
//   STAGES    number of cascaded stages
//   REG_READY 1: skid-buffer stages, 0: single-register stages
//   OCC_W     width of occupancy (derived)
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-high; clears valid flags and data
//   flush      synchronous discard of all held entries (data left as is)
//   s_valid    upstream valid
//   s_ready    pipeline accepts upstream data this cycle
//   s_data     upstream payload
//   m_valid    downstream valid
//   m_ready    downstream accepts data this cycle
//   m_data     downstream payload
//   occupancy  number of valid entries held across all stages
// ---------------------------------------------------------------------------
module skid_pipeline #(
  parameter int DATA_W    = 8,
  parameter int STAGES    = 2,
  parameter bit REG_READY = 1'b1,
  parameter int OCC_W     = $clog2(STAGES * (REG_READY ? 2 : 1) + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [OCC_W-1:0]  occupancy
);

  // Total number of valid flags (main + skid in skid mode).
  localparam int NV = REG_READY ? 2 * STAGES : STAGES;

  logic              m_rdy_eff;
  logic              stage0_rdy;
  logic              last_vld;
  logic [DATA_W-1:0] last_data;
  logic              s_fire;
  logic [NV-1:0]     vld_nxt_w;
  logic [OCC_W-1:0]  occ_r;

  // A flushing cycle must not complete a downstream transfer.
  assign m_rdy_eff = m_ready & ~flush;
  assign s_ready   = stage0_rdy & ~reset & ~flush;
  assign m_valid   = last_vld & ~flush;
  assign m_data    = last_data;
  assign s_fire    = s_valid & s_ready;
  assign occupancy = occ_r;

  function automatic logic [OCC_W-1:0] count_ones(input logic [NV-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NV; i++) begin
      n = n + int'(v[i]);
    end
    return OCC_W'(n);
  endfunction

  if (REG_READY) begin : g_skid
    logic [STAGES-1:0] main_vld_w;
    logic [STAGES-1:0] skid_vld_w;
    logic [DATA_W-1:0] main_data_w [STAGES];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
      logic              main_vld_p, skid_vld_p;
      logic [DATA_W-1:0] main_data_p, skid_data_p;
      logic              main_vld_n, skid_vld_n;
      logic [DATA_W-1:0] main_data_n, skid_data_n;
      logic              in_vld, out_rdy, in_fire, out_fire;
      logic [DATA_W-1:0] in_data;

      if (g == 0) begin : g_in_first
        assign in_vld  = s_fire;
        assign in_data = s_data;
      end else begin : g_in_chain
        assign in_vld  = main_vld_w[g-1];
        assign in_data = main_data_w[g-1];
      end

      // Downstream ready is the next stage's registered ~skid_valid.
      if (g == STAGES - 1) begin : g_out_last
        assign out_rdy = m_rdy_eff;
      end else begin : g_out_chain
        assign out_rdy = ~skid_vld_w[g+1];
      end

      assign in_fire  = in_vld & ~skid_vld_p;
      assign out_fire = main_vld_p & out_rdy;

      always_comb begin
        main_vld_n  = main_vld_p;
        main_data_n = main_data_p;
        skid_vld_n  = skid_vld_p;
        skid_data_n = skid_data_p;
        if (out_fire) begin
          // Skid refills main first; a skid-full stage cannot accept input.
          if (skid_vld_p) begin
            main_data_n = skid_data_p;
            skid_vld_n  = 1'b0;
          end else if (in_fire) begin
            main_data_n = in_data;
          end else begin
            main_vld_n  = 1'b0;
          end
        end else if (in_fire) begin
          if (!main_vld_p) begin
            main_vld_n  = 1'b1;
            main_data_n = in_data;
          end else begin
            skid_vld_n  = 1'b1;
            skid_data_n = in_data;
          end
        end
      end

      // Stage register boundary
      always_ff @(posedge clk) begin
        if (reset) begin
          main_vld_p  <= 1'b0;
          skid_vld_p  <= 1'b0;
          main_data_p <= '0;
          skid_data_p <= '0;
        end else if (flush) begin
          main_vld_p  <= 1'b0;
          skid_vld_p  <= 1'b0;
        end else begin
          main_vld_p  <= main_vld_n;
          skid_vld_p  <= skid_vld_n;
          main_data_p <= main_data_n;
          skid_data_p <= skid_data_n;
        end
      end

      assign main_vld_w[g]      = main_vld_p;
      assign skid_vld_w[g]      = skid_vld_p;
      assign main_data_w[g]     = main_data_p;
      assign vld_nxt_w[2*g]     = main_vld_n;
      assign vld_nxt_w[2*g + 1] = skid_vld_n;
    end

    assign stage0_rdy = ~skid_vld_w[0];
    assign last_vld   = main_vld_w[STAGES-1];
    assign last_data  = main_data_w[STAGES-1];

  end else begin : g_single
    logic [STAGES-1:0] vld_w;
    logic [DATA_W-1:0] data_w [STAGES];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
      logic              vld_p, vld_n;
      logic [DATA_W-1:0] data_p, data_n;
      logic              in_vld, in_rdy, out_rdy, in_fire, out_fire;
      logic [DATA_W-1:0] in_data;

      if (g == 0) begin : g_in_first
        assign in_vld  = s_fire;
        assign in_data = s_data;
      end else begin : g_in_chain
        assign in_vld  = vld_w[g-1];
        assign in_data = data_w[g-1];
      end

      // The ready chain ~valid | next_ready unrolls to: downstream ready,
      // or any later stage empty. Written flat from registered flags.
      if (g == STAGES - 1) begin : g_out_last
        assign out_rdy = m_rdy_eff;
      end else begin : g_out_chain
        assign out_rdy = m_rdy_eff | ~(&vld_w[STAGES-1:g+1]);
      end

      assign in_rdy   = ~vld_p | out_rdy;
      assign in_fire  = in_vld & in_rdy;
      assign out_fire = vld_p & out_rdy;
      assign vld_n    = in_fire | (vld_p & ~out_fire);
      assign data_n   = in_fire ? in_data : data_p;

      // Stage register boundary
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p  <= 1'b0;
          data_p <= '0;
        end else if (flush) begin
          vld_p  <= 1'b0;
        end else begin
          vld_p  <= vld_n;
          data_p <= data_n;
        end
      end

      assign vld_w[g]     = vld_p;
      assign data_w[g]    = data_p;
      assign vld_nxt_w[g] = vld_n;
    end

    assign stage0_rdy = m_rdy_eff | ~(&vld_w);
    assign last_vld   = vld_w[STAGES-1];
    assign last_data  = data_w[STAGES-1];
  end

  // Occupancy register boundary: reflects the flags after each edge.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ_r <= '0;
    end else begin
      occ_r <= count_ones(vld_nxt_w);
    end
  end

endmodule

// File: tb/tb_skid_pipeline.sv
module tb_skid_pipeline;

  logic       clk = 1'b0;
  logic       reset;
  // DUT A: STAGES=2, REG_READY=1
  logic       flush, s_valid, s_ready, m_valid, m_ready;
  logic [7:0] s_data, m_data;
  logic [2:0] occupancy;
  // DUT B: STAGES=3, REG_READY=0
  logic       flush0, s_valid0, s_ready0, m_valid0, m_ready0;
  logic [7:0] s_data0, m_data0;
  logic [1:0] occupancy0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  skid_pipeline #(.DATA_W(8), .STAGES(2), .REG_READY(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .occupancy(occupancy)
  );

  skid_pipeline #(.DATA_W(8), .STAGES(3), .REG_READY(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush0),
    .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0),
    .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0),
    .occupancy(occupancy0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    flush0 = 1'b0; s_valid0 = 1'b0; s_data0 = 8'h00; m_ready0 = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready_during got=%b exp=0", s_ready); end
    checks++;
    if (s_ready0 !== 1'b0) begin failures++; $display("FAIL reset_s_ready0_during got=%b exp=0", s_ready0); end
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || occupancy !== 3'd0) begin
      failures++; $display("FAIL reset_outputs got v=%b d=%h occ=%0d exp v=0 d=00 occ=0", m_valid, m_data, occupancy);
    end
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready_after got=%b exp=1", s_ready); end
    checks++;
    if (m_valid0 !== 1'b0 || m_data0 !== 8'h00 || occupancy0 !== 2'd0 || s_ready0 !== 1'b1) begin
      failures++; $display("FAIL reset_outputs0 got v=%b d=%h occ=%0d rdy=%b", m_valid0, m_data0, occupancy0, s_ready0);
    end
  endtask

  // 0x11,0x22,0x33 back-to-back with m_ready=1.
  task automatic test_back_to_back();
    logic [7:0] din   [3] = '{8'h11, 8'h22, 8'h33};
    logic       exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_d [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    logic [2:0] exp_o [6] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd1, 3'd0};
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      s_valid = (c < 3);
      s_data  = (c < 3) ? din[c] : 8'h00;
      #1;
      checks++;
      if (m_valid !== exp_v[c] || (exp_v[c] && m_data !== exp_d[c])) begin
        failures++; $display("FAIL b2b_out_c%0d got v=%b d=%h exp v=%b d=%h", c, m_valid, m_data, exp_v[c], exp_d[c]);
      end
      checks++;
      if (occupancy !== exp_o[c]) begin
        failures++; $display("FAIL b2b_occ_c%0d got=%0d exp=%0d", c, occupancy, exp_o[c]);
      end
      if (c < 3) begin
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL b2b_s_ready_c%0d got=%b exp=1", c, s_ready); end
      end
      tick();
    end
    s_valid = 1'b0;
  endtask

  // Fill with m_ready=0, then release and drain 0x01..0x08.
  task automatic test_full();
    int         accepted = 0;
    int         nxt_in   = 1;
    int         nxt_out  = 1;
    bit         started  = 0;
    bit         gap      = 0;
    logic       rdy_seq [8];
    m_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      s_valid = 1'b1;
      s_data  = 8'(nxt_in);
      #1;
      rdy_seq[c] = s_ready;
      if (s_valid && s_ready) begin accepted++; nxt_in++; end
      tick();
    end
    checks++;
    if (accepted !== 4) begin failures++; $display("FAIL full_accepted got=%0d exp=4", accepted); end
    checks++;
    if (rdy_seq[3] !== 1'b1 || rdy_seq[4] !== 1'b0 || rdy_seq[7] !== 1'b0) begin
      failures++; $display("FAIL full_s_ready_seq got c3=%b c4=%b c7=%b exp 1 0 0", rdy_seq[3], rdy_seq[4], rdy_seq[7]);
    end
    checks++;
    if (occupancy !== 3'd4) begin failures++; $display("FAIL full_occ got=%0d exp=4", occupancy); end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h01) begin
      failures++; $display("FAIL full_head got v=%b d=%h exp v=1 d=01", m_valid, m_data);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 40 && nxt_out <= 8; c++) begin
      s_valid = (nxt_in <= 8);
      s_data  = 8'(nxt_in);
      #1;
      if (m_valid) begin
        started = 1;
        checks++;
        if (m_data !== 8'(nxt_out)) begin
          failures++; $display("FAIL full_drain_order got=%h exp=%h", m_data, 8'(nxt_out));
        end
        nxt_out++;
      end else if (started) begin
        gap = 1;
      end
      if (s_valid && s_ready) nxt_in++;
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (nxt_out !== 9) begin failures++; $display("FAIL full_drain_count got=%0d exp=8", nxt_out - 1); end
    checks++;
    if (gap !== 1'b0) begin failures++; $display("FAIL full_drain_gap got=1 exp=0"); end
  endtask

  // Random handshakes, incrementing payload, scoreboard by counter.
  task automatic test_random();
    localparam int N = 10000;
    int tx = 0, rx = 0, bad_order = 0, dep = 0, unstable = 0;
    logic sr1, sr2, hold_v;
    logic [7:0] hold_d;
    bit in_fire, out_fire;
    hold_v = 1'b0; hold_d = 8'h00;
    s_valid = 1'b0;
    for (int c = 0; c < 60000 && rx < N; c++) begin
      if (!(s_valid && !in_fire)) begin
        s_valid = (tx < N) && ($urandom_range(0, 3) != 0);
        s_data  = 8'(tx);
      end
      m_ready = (tx >= N) || ($urandom_range(0, 3) != 0);
      #1;
      sr1 = s_ready;
      m_ready = ~m_ready;
      #1;
      sr2 = s_ready;
      m_ready = ~m_ready;
      #1;
      if (sr1 !== sr2) dep++;
      if (hold_v && (m_valid !== 1'b1 || m_data !== hold_d)) unstable++;
      in_fire  = s_valid && s_ready;
      out_fire = m_valid && m_ready;
      if (out_fire) begin
        if (m_data !== 8'(rx)) bad_order++;
        rx++;
      end
      if (in_fire) tx++;
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    checks++;
    if (rx !== N || tx !== N) begin failures++; $display("FAIL random_count got tx=%0d rx=%0d exp=%0d", tx, rx, N); end
    checks++;
    if (bad_order !== 0) begin failures++; $display("FAIL random_order got_errors=%0d exp=0", bad_order); end
    checks++;
    if (dep !== 0) begin failures++; $display("FAIL random_ready_dep got=%0d exp=0", dep); end
    checks++;
    if (unstable !== 0) begin failures++; $display("FAIL random_m_stable got=%0d exp=0", unstable); end
    checks++;
    if (occupancy !== 3'd0) begin failures++; $display("FAIL random_final_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_flush();
    int n_out = 0;
    logic [7:0] first_d = 8'h00;
    m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      s_valid = 1'b1; s_data = 8'(8'hC0 + c);
      tick();
    end
    checks++;
    if (occupancy !== 3'd3) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=3", occupancy); end
    flush = 1'b1; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
      failures++; $display("FAIL flush_cycle got s_ready=%b m_valid=%b exp 0 0", s_ready, m_valid);
    end
    tick();
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    #1;
    checks++;
    if (occupancy !== 3'd0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
      failures++; $display("FAIL flush_after got occ=%0d m_valid=%b s_ready=%b exp 0 0 1", occupancy, m_valid, s_ready);
    end
    s_valid = 1'b1; s_data = 8'hAA;
    tick();
    s_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (m_valid && m_ready) begin
        if (n_out == 0) first_d = m_data;
        n_out++;
      end
      tick();
    end
    checks++;
    if (n_out !== 1 || first_d !== 8'hAA) begin
      failures++; $display("FAIL flush_next_beat got count=%0d d=%h exp count=1 d=aa", n_out, first_d);
    end
  endtask

  // Single-register stages: full pipeline accepts and emits in one cycle.
  task automatic test_single_stage();
    logic [7:0] exp_d [4] = '{8'h01, 8'h02, 8'h03, 8'h5A};
    m_ready0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      s_valid0 = 1'b1; s_data0 = 8'(c + 1);
      tick();
    end
    s_valid0 = 1'b0;
    #1;
    checks++;
    if (occupancy0 !== 2'd3 || s_ready0 !== 1'b0) begin
      failures++; $display("FAIL single_full got occ=%0d s_ready=%b exp 3 0", occupancy0, s_ready0);
    end
    m_ready0 = 1'b1; s_valid0 = 1'b1; s_data0 = 8'h5A;
    #1;
    checks++;
    if (s_ready0 !== 1'b1 || m_valid0 !== 1'b1 || m_data0 !== 8'h01) begin
      failures++; $display("FAIL single_same_cycle got s_ready=%b m_valid=%b d=%h exp 1 1 01", s_ready0, m_valid0, m_data0);
    end
    tick();
    s_valid0 = 1'b0;
    checks++;
    if (occupancy0 !== 2'd3) begin failures++; $display("FAIL single_occ_hold got=%0d exp=3", occupancy0); end
    for (int c = 1; c < 4; c++) begin
      #1;
      checks++;
      if (m_valid0 !== 1'b1 || m_data0 !== exp_d[c]) begin
        failures++; $display("FAIL single_drain_%0d got v=%b d=%h exp v=1 d=%h", c, m_valid0, m_data0, exp_d[c]);
      end
      tick();
    end
    checks++;
    if (m_valid0 !== 1'b0 || occupancy0 !== 2'd0) begin
      failures++; $display("FAIL single_empty got v=%b occ=%0d exp 0 0", m_valid0, occupancy0);
    end
  endtask

  task automatic test_reset_midstream();
    int n_out = 0;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h3C; tick();
    s_data = 8'h4D; tick();
    s_valid = 1'b0;
    checks++;
    if (occupancy !== 3'd2 || m_valid !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre got occ=%0d m_valid=%b exp 2 1", occupancy, m_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_s_ready_during got=%b exp=0", s_ready); end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || occupancy !== 3'd0 || s_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_after got v=%b d=%h occ=%0d rdy=%b exp 0 00 0 1", m_valid, m_data, occupancy, s_ready);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (m_valid) n_out++;
      tick();
    end
    checks++;
    if (n_out !== 0) begin failures++; $display("FAIL rst_mid_no_emit got=%0d exp=0", n_out); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_random();
    test_flush();
    test_single_stage();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
